// File: rtl/mips8_pkg.sv
// Shared MIPS8 definitions: opcode field geometry, opcode numbering and fetch FSM states.
// ST_HALT exists only when FETCH_ILLEGAL_TRAP_EN is defined.
package mips8_pkg;

    localparam int OPCODE_W    = 5;
    localparam int NUM_OPCODES = 18;

    // Opcode occupies the top OPCODE_W bits of the instruction word.
    localparam int OPC_FIELD_W  = OPCODE_W;
    localparam int OPND_FROM_TOP = OPCODE_W;

    localparam logic [OPCODE_W-1:0] OP_NOP = 5'd0;
    localparam logic [OPCODE_W-1:0] OP_MOV = 5'd1;
    localparam logic [OPCODE_W-1:0] OP_LDI = 5'd2;
    localparam logic [OPCODE_W-1:0] OP_LD  = 5'd3;
    localparam logic [OPCODE_W-1:0] OP_ST  = 5'd4;
    localparam logic [OPCODE_W-1:0] OP_ADD = 5'd5;
    localparam logic [OPCODE_W-1:0] OP_SUB = 5'd6;
    localparam logic [OPCODE_W-1:0] OP_AND = 5'd7;
    localparam logic [OPCODE_W-1:0] OP_OR  = 5'd8;
    localparam logic [OPCODE_W-1:0] OP_XOR = 5'd9;
    localparam logic [OPCODE_W-1:0] OP_NOT = 5'd10;
    localparam logic [OPCODE_W-1:0] OP_CMP = 5'd11;
    localparam logic [OPCODE_W-1:0] OP_JZ  = 5'd12;
    localparam logic [OPCODE_W-1:0] OP_JNZ = 5'd13;
    localparam logic [OPCODE_W-1:0] OP_JL  = 5'd14;
    localparam logic [OPCODE_W-1:0] OP_JG  = 5'd15;
    localparam logic [OPCODE_W-1:0] OP_JMP = 5'd16;
    localparam logic [OPCODE_W-1:0] OP_HLT = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE
`ifdef FETCH_ILLEGAL_TRAP_EN
        , ST_HALT
`endif
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory req/ack bus between the fetch stage (master) and imem (slave).
interface fetch_unit_if #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16
);
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_ack;
    logic [INSTR_WIDTH-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_unit_branch_resolve.sv
// Branch-taken decision from ControlUnit jump strobes and the flags register.
module branch_resolve (
    input  logic is_jz,
    input  logic is_jnz,
    input  logic is_jl,
    input  logic is_jg,
    input  logic is_jump,
    input  logic flag_z,
    input  logic flag_l,
    input  logic flag_g,
    output logic taken
);
    // Any satisfied term wins; strobes are not assumed one-hot.
    assign taken = is_jump | (is_jz & flag_z) | (is_jnz & ~flag_z)
                 | (is_jl & flag_l) | (is_jg & flag_g);
endmodule

// File: rtl/fetch_unit.sv
// MIPS8 fetch/branch stage: PC + IR, imem req/ack fetch, issue to decode with stall.
// FETCH_ILLEGAL_TRAP_EN: opcodes >= NUM_OPCODES halt the stage and raise illegal.
module fetch_unit
    import mips8_pkg::*;
#(
    parameter int                  PC_WIDTH    = 8,
    parameter int                  INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    fetch_unit_if.master                    imem,
    output logic [OPCODE_W-1:0]             opcode,
    output logic [INSTR_WIDTH-OPCODE_W-1:0] operand,
    output logic                            instr_valid,
    input  logic                            stall,
    input  logic                            is_jz,
    input  logic                            is_jnz,
    input  logic                            is_jl,
    input  logic                            is_jg,
    input  logic                            is_jump,
    input  logic                            flag_z,
    input  logic                            flag_l,
    input  logic                            flag_g,
    input  logic [PC_WIDTH-1:0]             branch_target,
    output logic [PC_WIDTH-1:0]             pc,
    output logic                            illegal
);
    fetch_state_e           state;
    logic [INSTR_WIDTH-1:0] ir;
    logic                   req_q;
    logic                   taken;

    branch_resolve u_br (
        .is_jz   (is_jz),
        .is_jnz  (is_jnz),
        .is_jl   (is_jl),
        .is_jg   (is_jg),
        .is_jump (is_jump),
        .flag_z  (flag_z),
        .flag_l  (flag_l),
        .flag_g  (flag_g),
        .taken   (taken)
    );

    assign opcode         = ir[INSTR_WIDTH-1 -: OPC_FIELD_W];
    assign operand        = ir[INSTR_WIDTH-OPND_FROM_TOP-1:0];
    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;

`ifdef FETCH_ILLEGAL_TRAP_EN
    logic ill_q;
    assign illegal = ill_q;
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            ir          <= '0;
            req_q       <= 1'b0;
            instr_valid <= 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
            ill_q       <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_FETCH;
                    req_q <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem.imem_ack) begin
                        ir          <= imem.imem_rdata;
                        req_q       <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!stall) begin
                        instr_valid <= 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
                        if (opcode >= OPCODE_W'(NUM_OPCODES)) begin
                            ill_q <= 1'b1;
                            state <= ST_HALT;
                        end else begin
                            pc    <= taken ? branch_target : pc + PC_WIDTH'(1);
                            req_q <= 1'b1;
                            state <= ST_FETCH;
                        end
`else
                        pc    <= taken ? branch_target : pc + PC_WIDTH'(1);
                        req_q <= 1'b1;
                        state <= ST_FETCH;
`endif
                    end
                end
`ifdef FETCH_ILLEGAL_TRAP_EN
                ST_HALT: ;  // sticky until reset
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table with imem scoreboard plus reset/illegal sequences.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, is_jz, is_jnz, is_jl, is_jg, is_jump;
    logic        flag_z, flag_l, flag_g;
    logic [7:0]  branch_target;
    logic [4:0]  opcode;
    logic [10:0] operand;
    logic        instr_valid, illegal;
    logic [7:0]  pc;

    int n_chk  = 0;
    int n_fail = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  cur_pc;

    fetch_unit_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) imem_bus ();

    fetch_unit #(.PC_WIDTH(8), .INSTR_WIDTH(16), .RESET_PC(8'h00)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem          (imem_bus),
        .opcode        (opcode),
        .operand       (operand),
        .instr_valid   (instr_valid),
        .stall         (stall),
        .is_jz         (is_jz),
        .is_jnz        (is_jnz),
        .is_jl         (is_jl),
        .is_jg         (is_jg),
        .is_jump       (is_jump),
        .flag_z        (flag_z),
        .flag_l        (flag_l),
        .flag_g        (flag_g),
        .branch_target (branch_target),
        .pc            (pc),
        .illegal       (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] instr;
        int          ack_dly;
        int          stall_n;
        logic [4:0]  jmp;     // {jz,jnz,jl,jg,jump}
        logic [2:0]  flg;     // {z,l,g}
        logic [7:0]  tgt;
        logic [7:0]  exp_pc;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int w = 0;
        logic [15:0] e;
        while (!imem_bus.imem_req && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("fetch_latency", w, 0);
        chk("fetch_addr", imem_bus.imem_addr, cur_pc);
        chk("fetch_pc", pc, cur_pc);
        repeat (v.ack_dly) begin
            @(negedge clk);
            chk("addr_stable", imem_bus.imem_addr, cur_pc);
            chk("no_valid_in_fetch", instr_valid, 0);
        end
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = v.instr;
        exp_q.push_back(v.instr);
        @(negedge clk);
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 16'($urandom);
        chk("issue_valid", instr_valid, 1);
        chk("issue_req_low", imem_bus.imem_req, 0);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        chk("opcode", opcode, e[15:11]);
        chk("operand", operand, e[10:0]);
        if (v.stall_n > 0) begin
            stall = 1'b1;
            repeat (v.stall_n) begin
                @(negedge clk);
                chk("stall_opcode", opcode, e[15:11]);
                chk("stall_operand", operand, e[10:0]);
                chk("stall_pc", pc, cur_pc);
                chk("stall_req", imem_bus.imem_req, 0);
                chk("stall_valid", instr_valid, 1);
            end
        end
        stall = 1'b0;
        {is_jz, is_jnz, is_jl, is_jg, is_jump} = v.jmp;
        {flag_z, flag_l, flag_g} = v.flg;
        branch_target = v.tgt;
        @(negedge clk);
        {is_jz, is_jnz, is_jl, is_jg, is_jump} = '0;
        chk("next_pc", pc, v.exp_pc);
        chk("refetch_req", imem_bus.imem_req, 1);
        chk("valid_drop", instr_valid, 0);
        cur_pc = v.exp_pc;
    endtask

    initial begin
        vecs[0]  = '{16'h0801, 0, 0, 5'b00000, 3'b000, 8'h00, 8'h01};
        vecs[1]  = '{16'h1234, 2, 0, 5'b00000, 3'b000, 8'h00, 8'h02};
        vecs[2]  = '{16'h2345, 0, 0, 5'b00000, 3'b000, 8'h00, 8'h03};
        vecs[3]  = '{16'h4abc, 0, 5, 5'b00000, 3'b000, 8'h00, 8'h04};
        vecs[4]  = '{16'h6000, 0, 0, 5'b10000, 3'b100, 8'h40, 8'h40};
        vecs[5]  = '{16'h6000, 0, 0, 5'b10000, 3'b000, 8'h40, 8'h41};
        vecs[6]  = '{16'h6800, 0, 0, 5'b01000, 3'b000, 8'h40, 8'h40};
        vecs[7]  = '{16'h6800, 0, 0, 5'b01000, 3'b100, 8'h40, 8'h41};
        vecs[8]  = '{16'h7000, 0, 0, 5'b00100, 3'b010, 8'h40, 8'h40};
        vecs[9]  = '{16'h7000, 0, 0, 5'b00100, 3'b101, 8'h40, 8'h41};
        vecs[10] = '{16'h7800, 0, 0, 5'b00010, 3'b001, 8'h40, 8'h40};
        vecs[11] = '{16'h7800, 0, 0, 5'b00010, 3'b000, 8'h40, 8'h41};
        vecs[12] = '{16'h8000, 0, 0, 5'b00001, 3'b000, 8'h40, 8'h40};
        vecs[13] = '{16'h6000, 0, 0, 5'b10100, 3'b010, 8'h40, 8'h40};
        vecs[14] = '{16'h8000, 0, 0, 5'b00001, 3'b000, 8'hFF, 8'hFF};
        vecs[15] = '{16'h0001, 0, 0, 5'b00000, 3'b000, 8'h40, 8'h00};

        rst_n = 1'b0;
        stall = 1'b0;
        {is_jz, is_jnz, is_jl, is_jg, is_jump} = '0;
        {flag_z, flag_l, flag_g} = '0;
        branch_target = 8'h00;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 16'h0000;

        // Reset state and first fetch
        repeat (2) @(negedge clk);
        chk("rst_req", imem_bus.imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_operand", operand, 0);
        chk("rst_pc", pc, 8'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_req", imem_bus.imem_req, 0);
        @(negedge clk);
        chk("first_req", imem_bus.imem_req, 1);
        chk("first_addr", imem_bus.imem_addr, 8'h00);
        cur_pc = 8'h00;

        for (int i = 0; i < 16; i++) run_vec(vecs[i]);

        // Illegal opcode 20 fetched at pc 0
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 16'hA000;
        exp_q.push_back(16'hA000);
        @(negedge clk);
        imem_bus.imem_ack = 1'b0;
        chk("ill_valid", instr_valid, 1);
        chk("ill_opcode", opcode, exp_q.pop_front() >> 11);
        @(negedge clk);
`ifdef FETCH_ILLEGAL_TRAP_EN
        chk("ill_flag", illegal, 1);
        chk("ill_valid_drop", instr_valid, 0);
        chk("ill_pc", pc, cur_pc);
        repeat (5) begin
            @(negedge clk);
            chk("halt_req", imem_bus.imem_req, 0);
            chk("halt_illegal", illegal, 1);
            chk("halt_pc", pc, cur_pc);
        end
`else
        chk("ill_flag", illegal, 0);
        chk("ill_pc", pc, cur_pc + 8'h01);
        chk("ill_req", imem_bus.imem_req, 1);
`endif

        // Fresh reset, one instruction, then reset while awaiting ack
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rerun_req", imem_bus.imem_req, 1);
        cur_pc = 8'h00;
        run_vec('{16'h2800, 1, 0, 5'b00000, 3'b000, 8'h00, 8'h01});
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req", imem_bus.imem_req, 0);
        chk("midrst_pc", pc, 8'h00);
        chk("midrst_valid", instr_valid, 0);
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 16'h5555;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("late_ack_idle_req", imem_bus.imem_req, 0);
        chk("late_ack_idle_valid", instr_valid, 0);
        @(negedge clk);
        chk("late_ack_fetch_req", imem_bus.imem_req, 1);
        chk("late_ack_valid", instr_valid, 0);
        chk("late_ack_opcode", opcode, 0);
        imem_bus.imem_ack = 1'b0;
        cur_pc = 8'h00;
        run_vec('{16'h3000, 0, 0, 5'b00000, 3'b000, 8'h00, 8'h01});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and branch-resolution stage of the MIPS8 core; produces the `opcode` that drives `ControlUnit`.
- Consumes `ControlUnit`'s jump-class outputs (`is_jz`, `is_jnz`, `is_jl`, `is_jg`, `is_jump`) together with the flags register to choose the next PC.
- Holds the program counter and instruction register, and fetches 16-bit instructions from instruction memory over a req/ack handshake.
- Presents each instruction to decode until downstream accepts it.

Parameters:
- PC_WIDTH, 8, program counter / instruction-memory address width.
- INSTR_WIDTH, 16, instruction width; opcode is bits [INSTR_WIDTH-1 -: 5].
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_WIDTH  fetch address, equal to pc.
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  INSTR_WIDTH  fetched instruction.
- opcode  out  5  IR opcode field, to `ControlUnit`.
- operand  out  INSTR_WIDTH-5  IR low bits (register/immediate fields).
- instr_valid  out  1  IR holds an instruction for decode.
- stall  in  1  downstream not ready; hold the current instruction.
- is_jz, is_jnz, is_jl, is_jg, is_jump  in  1 each  from `ControlUnit`.
- flag_z, flag_l, flag_g  in  1 each  zero / less / greater flags.
- branch_target  in  PC_WIDTH  jump destination from datapath.
- pc  out  PC_WIDTH  current program counter.
- illegal  out  1  illegal-opcode trap (see Optional Feature).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, pc=RESET_PC, IR=0.
  - imem_req=0, instr_valid=0, illegal=0; opcode/operand read 0.
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE: one cycle after reset release, then → FETCH.
- FETCH:
  - imem_req=1; imem_addr=pc, held stable until ack.
  - On an edge with imem_ack=1: IR<=imem_rdata, → ISSUE.
  - imem_ack while imem_req=0 is ignored.
- ISSUE:
  - instr_valid=1; opcode/operand driven from IR.
  - `ControlUnit` outputs are combinational from opcode and sampled this cycle.
  - stall=1: remain in ISSUE; IR and pc unchanged.
  - stall=0, on the edge:
    - taken = is_jump | (is_jz & flag_z) | (is_jnz & ~flag_z) | (is_jl & flag_l) | (is_jg & flag_g).
    - pc <= taken ? branch_target : pc+1.
    - → FETCH.
- Simultaneous jump strobes: taken if any term is satisfied; branch_target is always the destination.
- PC arithmetic: modulo 2^PC_WIDTH; pc=8'hFF not taken → 8'h00.
- Latency:
  - Minimum 2 cycles per instruction (ack in the first FETCH cycle, no stall).
  - Reset release to first imem_req: 1 cycle.
- Reset mid-FETCH or mid-ISSUE: immediate abort, all outputs to reset values. A late imem_ack is ignored because state is IDLE.
- HALT: reachable only with the optional feature enabled.

Optional Feature:
- Macro: FETCH_ILLEGAL_TRAP_EN.
- Enabled, opcode >= 18 (NUM_OPCODES) in ISSUE with stall=0:
  - → HALT; pc unchanged.
  - illegal=1, instr_valid=0, imem_req=0.
  - Held until reset.
- Disabled: opcodes >= 18 advance as no-ops (pc+1); illegal tied 0; HALT state absent.

Decomposition:
- Package mips8_pkg:
  - OPCODE_W=5, NUM_OPCODES=18.
  - Fetch state enum.
  - Opcode field slice constants.
  - Named opcode localparams shared with `ControlUnit`.
- Sub-module branch_resolve: combinational taken logic from the five strobes and three flags. Reused by a later pipelined core.

Test Plan:
- Reset/first fetch, RESET_PC=0: release rst_n → imem_req=0 for one cycle, then imem_req=1 with imem_addr=0.
- Straight-line code, ack same cycle, stall=0: instr_valid every 2nd cycle; pc sequence 0,1,2,3.
- Stall: hold stall=1 for 5 ISSUE cycles → opcode, operand and pc unchanged, imem_req=0; release → pc+1.
- Branches, branch_target=8'h40:
  - is_jz with flag_z=1 → pc=8'h40.
  - is_jz with flag_z=0 → pc+1.
  - is_jnz, is_jl, is_jg likewise against their flags.
  - is_jump alone → 8'h40.
- Wrap and mid-reset:
  - pc=8'hFF, non-branch → pc=8'h00.
  - Assert rst_n=0 while in FETCH awaiting ack → imem_req drops without a clock edge; a subsequent ack is ignored.
- Illegal opcode, feature enabled: fetch opcode 5'd20 → illegal=1, pc frozen, no further imem_req. Feature disabled: same stimulus → pc+1, illegal=0.
